// File: rtl/branch_resolve_if.sv
// branch_resolve_if: prediction, resolution, training, redirect and statistics signals of the branch resolve unit
interface branch_resolve_if #(parameter int CNT_W = 32);
  logic             pred_valid;
  logic [31:0]      pred_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             res_valid;
  logic [31:0]      res_pc;
  logic [6:0]       res_opcode;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             full;
  logic             update;
  logic [7:0]       update_address;
  logic             branch_taken;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;
  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_pc, res_opcode, res_taken, res_target,
    input  full, update, update_address, branch_taken,
    input  redirect_valid, redirect_pc, flush, branch_cnt, mispredict_cnt
  );
  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_pc, res_opcode, res_taken, res_target,
    output full, update, update_address, branch_taken,
    output redirect_valid, redirect_pc, flush, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: queues fetch predictions, checks them at EX, trains the predictor and redirects/flushes on mispredict
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic            clk,
  input logic            rst,
  branch_resolve_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [6:0] OP_BR = 7'b1100011;
  logic [0:0]       state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]      pc_mem [DEPTH];
  logic [31:0]      tg_mem [DEPTH];
  logic [DEPTH-1:0] tk_mem;
  logic             update_q, update_d, bt_q, bt_d, rv_q, rv_d, flush_q, flush_d;
  logic [7:0]       addr_q, addr_d;
  logic [31:0]      rpc_q, rpc_d;
  logic [CNT_W-1:0] bc_q, bc_d, mc_q, mc_d;
  logic             run, empty, full, acc, pop, push, mis, train, htk;
  logic [31:0]      hpc, htg, cpc;
  // head compare, queue control and next-state selection
  always_comb begin
    run     = state_q == RUN;
    empty   = wptr_q == rptr_q;
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    acc     = run && bus.res_valid;
    pop     = acc && !empty;
    hpc     = empty ? bus.res_pc : pc_mem[rptr_q[AW-1:0]];
    htk     = !empty && tk_mem[rptr_q[AW-1:0]];
    htg     = tg_mem[rptr_q[AW-1:0]];
    mis     = acc && (hpc != bus.res_pc || htk != bus.res_taken || (bus.res_taken && htg != bus.res_target));
    push    = run && bus.pred_valid && !mis && (!full || pop);
    train   = acc && bus.res_opcode == OP_BR;
    cpc     = bus.res_taken ? bus.res_target : bus.res_pc + 32'd4;
    state_d = mis ? FLUSH : (!run && fcnt_q == '0) ? RUN : state_q;
    fcnt_d  = mis ? FW'(FLUSH_CYCLES - 1) : (!run && fcnt_q != '0) ? fcnt_q - 1'b1 : fcnt_q;
    wptr_d  = mis ? '0 : wptr_q + {{AW{1'b0}}, push};
    rptr_d  = mis ? '0 : rptr_q + {{AW{1'b0}}, pop};
    update_d = train;
    addr_d   = train ? bus.res_pc[7:0] : addr_q;
    bt_d     = train ? bus.res_taken : bt_q;
    rv_d     = mis;
    rpc_d    = mis ? cpc : rpc_q;
    flush_d  = mis || (!run && fcnt_q != '0);
    bc_d     = bc_q + {{(CNT_W-1){1'b0}}, acc && bc_q != '1};
    mc_d     = mc_q + {{(CNT_W-1){1'b0}}, mis && mc_q != '1};
  end
  // control state, pointers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      fcnt_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      update_q <= 1'b0;
      addr_q   <= '0;
      bt_q     <= 1'b0;
      rv_q     <= 1'b0;
      rpc_q    <= '0;
      flush_q  <= 1'b0;
      bc_q     <= '0;
      mc_q     <= '0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      update_q <= update_d;
      addr_q   <= addr_d;
      bt_q     <= bt_d;
      rv_q     <= rv_d;
      rpc_q    <= rpc_d;
      flush_q  <= flush_d;
      bc_q     <= bc_d;
      mc_q     <= mc_d;
    end
  end
  // prediction storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr_q[AW-1:0]] <= bus.pred_pc;
      tk_mem[wptr_q[AW-1:0]] <= bus.pred_taken;
      tg_mem[wptr_q[AW-1:0]] <= bus.pred_target;
    end
  end
  assign bus.full           = full;
  assign bus.update         = update_q;
  assign bus.update_address = addr_q;
  assign bus.branch_taken   = bt_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.flush          = flush_q;
  assign bus.branch_cnt     = bc_q;
  assign bus.mispredict_cnt = mc_q;
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Branch resolution and training unit sitting at the EX stage, at the opposite end of the gshare predictor's predict/update interface. It keeps each prediction made at fetch in a small in-order queue. When EX resolves that instruction, it compares prediction against outcome. It then drives the predictor's `update`/`update_address`/`branch_taken` training port and, on mispredict, issues a redirect and a timed pipeline flush. It also keeps branch and mispredict statistics counters.

## Interface
Parameters:
- DEPTH, 4: in-flight prediction queue entries (power of two, ≥2).
- FLUSH_CYCLES, 2: cycles `flush` stays high after a mispredict (≥1).
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pred_valid  in  1  IF issued a control-flow instruction with a prediction this cycle.
- pred_pc  in  32  PC of that instruction.
- pred_taken  in  1  predicted direction.
- pred_target  in  32  predicted target; meaningful only if pred_taken.
- res_valid  in  1  EX resolves the oldest in-flight control-flow instruction this cycle.
- res_pc  in  32  PC of the resolving instruction.
- res_opcode  in  7  its opcode.
- res_taken  in  1  actual direction.
- res_target  in  32  actual taken target.
- full  out  1  queue full; IF must stall before issuing pred_valid.
- update  out  1  one-cycle training strobe to the predictor.
- update_address  out  8  res_pc[7:0] of the trained branch.
- branch_taken  out  1  actual direction for training.
- redirect_valid  out  1  one-cycle strobe; fetch must restart at redirect_pc.
- redirect_pc  out  32  correct next PC.
- flush  out  1  squash the IF/ID/EX wrong-path instructions.
- branch_cnt  out  CNT_W  resolved control-flow instructions.
- mispredict_cnt  out  CNT_W  mispredicts.

## Operation
- Queue: a circular FIFO of {pc, taken, target}. Read/write pointers are log2(DEPTH)+1 bits wide, and the wrap bit distinguishes full from empty.
  - A push happens on a pred_valid cycle while in RUN.
  - A pop happens on a res_valid cycle while in RUN with the queue non-empty.
  - Push and pop in the same cycle are allowed even when full; occupancy is unchanged.
  - A push while full with no pop is dropped, and pointers are unchanged.
- Resolution (res_valid in RUN): the head entry supplies the prediction. If the queue is empty, the implied prediction is not-taken, pc = res_pc.
  - correct_pc = res_taken ? res_target : res_pc + 32'd4 (mod 2^32).
  - A mispredict occurs if any of the following holds:
    - head.pc ≠ res_pc;
    - head.taken ≠ res_taken;
    - res_taken and head.target ≠ res_target.
- Training: update fires only for conditional branches (res_opcode = 7'b1100011), with branch_taken = res_taken. JAL (1101111) and JALR (1100111) are checked and counted but never trained.
- Counters: branch_cnt increments on every res_valid accepted in RUN. mispredict_cnt increments on each mispredict. Both saturate at all-ones.
- FSM:
  - RUN: normal operation. A mispredict goes to FLUSH and loads the flush counter with FLUSH_CYCLES−1.
  - FLUSH: the queue is cleared (both pointers 0) on entry. pred_valid and res_valid are ignored, since they are wrong-path. The counter decrements each cycle, and the FSM returns to RUN when the counter is 0 and flush drops.
- A pred_valid in the same cycle a mispredict is detected is not pushed.

## Timing
- Reset values:
  - update, branch_taken, redirect_valid, flush, full, and both counters are 0.
  - update_address and redirect_pc are 0.
  - The queue is empty and the FSM is in RUN.
- All outputs are registered except `full`, which is combinational from the pointers.
- Training latency: with res_valid in cycle N, update/update_address/branch_taken are valid in N+1 for one cycle. Counters reflect the event in N+1.
- Mispredict in cycle N:
  - redirect_valid is high in N+1 only, with redirect_pc = correct_pc.
  - flush is high in N+1 … N+FLUSH_CYCLES.
  - The FSM is back in RUN at N+FLUSH_CYCLES+1; pred_valid is accepted from that cycle.
- A mispredicted conditional branch still trains: update is high in N+1 together with redirect_valid.
- rst mid-FLUSH: the next cycle is RUN, all outputs are at reset values, and the queue is empty.

## Test plan
- Reset: hold rst 2 cycles → every output 0, full=0. Then 4 pushes with no pops → full=1 after the 4th. A 5th push is dropped, and the next 4 resolves match the first 4 entries.
- Correct prediction: push {pc=0x100, taken=1, target=0x140}; resolve opcode 1100011, taken=1, target=0x140 → N+1: update=1, update_address=0x00, branch_taken=1, no redirect/flush, branch_cnt=1, mispredict_cnt=0.
- Direction mispredict: push {pc=0x204, taken=0}; resolve taken=1, target=0x300 → N+1: redirect_valid=1, redirect_pc=0x300, update=1, update_address=0x04. flush is high for exactly 2 cycles, and the queue is empty afterwards.
- Target mispredict on JALR: push {pc=0x80, taken=1, target=0x90}; resolve opcode 1100111, taken=1, target=0xA0 → redirect_pc=0xA0, update=0, mispredict_cnt=1.
- Flush squashing: during FLUSH, drive pred_valid and res_valid each cycle → no push, no counter change, no update. The push in the first RUN cycle is accepted.
- Simultaneous push/pop at full, plus a not-taken mispredict: with the queue full, push and pop in the same cycle → full stays 1. Then resolve head {pc=0xFFFFFFFC, taken=1}, actual not-taken → redirect_pc=0x00000000 (wrap).
